// File: rtl/pc_fetch_control.sv
// Fetch program-counter control.
// Keeps the fetch PC, follows branch/jump redirects and marks the
// wrong-path bubble cycles that follow each redirect.
module pc_fetch_control #(
  parameter logic [31:0] RESET_PC     = 32'h00000000,
  parameter int unsigned GAP          = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] newAddress_branch,
  input  logic        jump,
  input  logic [31:0] jumpAddress,
  output logic [31:0] newAddress,
  output logic [31:0] newAddress_next,
  output logic        fetchValid,
  output logic        flush,
  output logic        misaligned,
  output logic [15:0] redirectCount
);

  localparam logic [31:0] GAP_W   = 32'(GAP);
  localparam logic [3:0]  FLUSH_W = 4'(FLUSH_CYCLES);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic [15:0] rc_q, rc_d;

  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] pc_next_s;

  // Sequential successor of the current PC; wraps modulo 2^32.
  assign pc_next_s       = pc_q + GAP_W;
  assign newAddress_next = pc_next_s;

  // Branch wins over jump when both arrive together.
  assign redirect_s = branchTaken | jump;
  assign target_s   = branchTaken ? newAddress_branch : jumpAddress;

  // Next-state and next-output logic for the RUN/FLUSH controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    rc_d    = rc_q;
    if (redirect_s) begin
      // A redirect is taken even under stall and restarts any bubble run.
      state_d = ST_FLUSH;
      cnt_d   = FLUSH_W;
      pc_d    = {target_s[31:2], 2'b00};
      mis_d   = |target_s[1:0];
      if (rc_q != 16'hFFFF) begin
        rc_d = rc_q + 16'd1;
      end else begin
        rc_d = rc_q;
      end
    end else if (stall) begin
      // Stalled: PC, state and bubble counter all hold.
      state_d = state_q;
      cnt_d   = cnt_q;
    end else begin
      pc_d = pc_next_s;
      case (state_q)
        ST_RUN: begin
          state_d = ST_RUN;
        end
        ST_FLUSH: begin
          // Leaving on the decrement that reaches zero gives exactly
          // FLUSH_CYCLES cycles with flush high.
          if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_FLUSH;
            cnt_d   = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
    flush_d = (state_d == ST_FLUSH);
    valid_d = (state_d == ST_RUN);
  end

  // State, PC and registered outputs with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      valid_q <= 1'b1;
      mis_q   <= 1'b0;
      rc_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      rc_q    <= rc_d;
    end
  end

  assign newAddress    = pc_q;
  assign flush         = flush_q;
  assign fetchValid    = valid_q;
  assign misaligned    = mis_q;
  assign redirectCount = rc_q;

endmodule

// File: tb/tb_pc_fetch_control.sv
// Directed testbench for pc_fetch_control with a small expected-value queue.
module tb_pc_fetch_control;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] newAddress_branch;
  logic        jump;
  logic [31:0] jumpAddress;
  logic [31:0] newAddress;
  logic [31:0] newAddress_next;
  logic        fetchValid;
  logic        flush;
  logic        misaligned;
  logic [15:0] redirectCount;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        fl;
    logic        mis;
    logic [15:0] rc;
  } exp_t;

  exp_t sb_q[$];

  pc_fetch_control dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .branchTaken       (branchTaken),
    .newAddress_branch (newAddress_branch),
    .jump              (jump),
    .jumpAddress       (jumpAddress),
    .newAddress        (newAddress),
    .newAddress_next   (newAddress_next),
    .fetchValid        (fetchValid),
    .flush             (flush),
    .misaligned        (misaligned),
    .redirectCount     (redirectCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, then
  // compare it against the DUT one time unit after the rising edge.
  task automatic step(input string tag, input logic rst, input logic st,
                      input logic br, input logic [31:0] ba,
                      input logic jp, input logic [31:0] ja,
                      input logic [31:0] epc, input logic efl,
                      input logic emis, input logic [15:0] erc);
    exp_t e;
    reset             = rst;
    stall             = st;
    branchTaken       = br;
    newAddress_branch = ba;
    jump              = jp;
    jumpAddress       = ja;
    e.pc  = epc;
    e.fl  = efl;
    e.mis = emis;
    e.rc  = erc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      failed++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".pc"},    newAddress,                     e.pc);
      chk({tag, ".next"},  newAddress_next,                e.pc + 32'd4);
      chk({tag, ".flush"}, {31'd0, flush},                 {31'd0, e.fl});
      chk({tag, ".valid"}, {31'd0, fetchValid},            {31'd0, ~e.fl});
      chk({tag, ".mis"},   {31'd0, misaligned},            {31'd0, e.mis});
      chk({tag, ".rc"},    {16'd0, redirectCount},         {16'd0, e.rc});
    end
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    reset = 1'b1; stall = 1'b0; branchTaken = 1'b0; jump = 1'b0;
    newAddress_branch = Z; jumpAddress = Z;

    //     tag       rst   stall br    baddr          jp    jaddr          pc             fl    mis   rc
    step("reset",   1'b1, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000000, 1'b0, 1'b0, 16'd0);
    step("idle1",   1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000004, 1'b0, 1'b0, 16'd0);
    step("idle2",   1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000008, 1'b0, 1'b0, 16'd0);
    step("idle3",   1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h0000000C, 1'b0, 1'b0, 16'd0);
    step("idle4",   1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000010, 1'b0, 1'b0, 16'd0);
    // Branch to 0x40: two bubble cycles, then RUN at 0x48.
    step("br40",    1'b0, 1'b0, 1'b1, 32'h00000040,  1'b0, Z,             32'h00000040, 1'b1, 1'b0, 16'd1);
    step("br40f2",  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000044, 1'b1, 1'b0, 16'd1);
    step("br40run", 1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000048, 1'b0, 1'b0, 16'd1);
    // Branch and jump together: branch wins, one count.
    step("both",    1'b0, 1'b0, 1'b1, 32'h00000080,  1'b1, 32'h00000200,  32'h00000080, 1'b1, 1'b0, 16'd2);
    step("bothf2",  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000084, 1'b1, 1'b0, 16'd2);
    step("bothrun", 1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000088, 1'b0, 1'b0, 16'd2);
    // Get to PC 0x20 in RUN, then stall.
    step("j18",     1'b0, 1'b0, 1'b0, Z,             1'b1, 32'h00000018,  32'h00000018, 1'b1, 1'b0, 16'd3);
    step("j18f2",   1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h0000001C, 1'b1, 1'b0, 16'd3);
    step("j18run",  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000020, 1'b0, 1'b0, 16'd3);
    step("stall1",  1'b0, 1'b1, 1'b0, Z,             1'b0, Z,             32'h00000020, 1'b0, 1'b0, 16'd3);
    step("stall2",  1'b0, 1'b1, 1'b0, Z,             1'b0, Z,             32'h00000020, 1'b0, 1'b0, 16'd3);
    step("stall3",  1'b0, 1'b1, 1'b0, Z,             1'b0, Z,             32'h00000020, 1'b0, 1'b0, 16'd3);
    // Jump accepted despite stall; stall inside FLUSH freezes the bubble count.
    step("stjmp",   1'b0, 1'b1, 1'b0, Z,             1'b1, 32'h00000100,  32'h00000100, 1'b1, 1'b0, 16'd4);
    step("flstall", 1'b0, 1'b1, 1'b0, Z,             1'b0, Z,             32'h00000100, 1'b1, 1'b0, 16'd4);
    step("stjf2",   1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000104, 1'b1, 1'b0, 16'd4);
    step("stjrun",  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000108, 1'b0, 1'b0, 16'd4);
    // Misaligned jump target.
    step("mis",     1'b0, 1'b0, 1'b0, Z,             1'b1, 32'h00000103,  32'h00000100, 1'b1, 1'b1, 16'd5);
    step("misoff",  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000104, 1'b1, 1'b0, 16'd5);
    step("misrun",  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000108, 1'b0, 1'b0, 16'd5);
    // Wrap past the top of the address space.
    step("jtop",    1'b0, 1'b0, 1'b0, Z,             1'b1, 32'hFFFFFFF4,  32'hFFFFFFF4, 1'b1, 1'b0, 16'd6);
    step("topf2",   1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'hFFFFFFF8, 1'b1, 1'b0, 16'd6);
    step("toprun",  1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'hFFFFFFFC, 1'b0, 1'b0, 16'd6);
    step("wrap",    1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000000, 1'b0, 1'b0, 16'd6);
    // Redirect in the first FLUSH cycle restarts the bubble run.
    step("b300",    1'b0, 1'b0, 1'b1, 32'h00000300,  1'b0, Z,             32'h00000300, 1'b1, 1'b0, 16'd7);
    step("rej400",  1'b0, 1'b0, 1'b0, Z,             1'b1, 32'h00000400,  32'h00000400, 1'b1, 1'b0, 16'd8);
    step("ref2",    1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000404, 1'b1, 1'b0, 16'd8);
    step("rerun",   1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000408, 1'b0, 1'b0, 16'd8);
    // Reset in the middle of a flush, with a competing redirect.
    step("b500",    1'b0, 1'b0, 1'b1, 32'h00000500,  1'b0, Z,             32'h00000500, 1'b1, 1'b0, 16'd9);
    step("rstfl",   1'b1, 1'b0, 1'b1, 32'h00000600,  1'b0, Z,             32'h00000000, 1'b0, 1'b0, 16'd0);
    step("postrst", 1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             32'h00000004, 1'b0, 1'b0, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_fetch_control.md
PC_FETCH_CONTROL -- requirements
Module: pc_fetch_control

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the PC value loaded on reset.
REQ-002 SHALL have parameter GAP, default 4, the byte increment per sequential instruction.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, the number of wrong-path bubble cycles per redirect; legal range 1..15.
REQ-004 SHALL provide: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL provide: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide: stall  input  1  hold the current PC.
REQ-007 SHALL provide: branchTaken  input  1  accept a branch redirect this cycle.
REQ-008 SHALL provide: newAddress_branch  input  32  branch target (PC+GAP+imm*GAP, computed upstream).
REQ-009 SHALL provide: jump  input  1  accept a jump redirect this cycle.
REQ-010 SHALL provide: jumpAddress  input  32  jump target.
REQ-011 SHALL provide: newAddress  output  32  current fetch PC.
REQ-012 SHALL provide: newAddress_next  output  32  newAddress+GAP, feeding the branch target adder.
REQ-013 SHALL provide: fetchValid  output  1  fetched instruction at newAddress is on the correct path.
REQ-014 SHALL provide: flush  output  1  kill younger in-flight instructions.
REQ-015 SHALL provide: misaligned  output  1  one-cycle pulse when an accepted target had bits [1:0] nonzero.
REQ-016 SHALL provide: redirectCount  output  16  count of accepted redirects.

Function
REQ-017 SHALL implement two states: RUN and FLUSH, plus a 4-bit bubble counter.
REQ-018 SHALL compute newAddress_next combinationally as newAddress+GAP modulo 2^32; 32'hFFFFFFFC+4 SHALL give 32'h00000000.
REQ-019 SHALL treat a redirect as accepted in any cycle where branchTaken or jump is high, in either state, regardless of stall.
REQ-020 SHALL give branchTaken priority over jump when both are high; the jump SHALL be dropped.
REQ-021 SHALL load the accepted target into newAddress at the next edge, with bits [1:0] forced to 00.
REQ-022 SHALL pulse misaligned high for exactly the cycle after acceptance if the raw target bits [1:0] were nonzero; otherwise low.
REQ-023 SHALL, on acceptance, enter FLUSH and load the counter with FLUSH_CYCLES; a redirect accepted during FLUSH SHALL reload the counter (restart).
REQ-024 SHALL, in FLUSH, hold flush=1 and fetchValid=0, decrement the counter each cycle not stalled, and return to RUN when it reaches 0.
REQ-025 SHALL, in FLUSH without a new redirect, advance newAddress by GAP each non-stalled cycle (fetching from the new target).
REQ-026 SHALL, in RUN without a redirect, advance newAddress by GAP when stall=0 and hold it when stall=1.
REQ-027 SHALL, in RUN, drive flush=0 and fetchValid=1.
REQ-028 SHALL have all outputs registered except newAddress_next.
REQ-029 SHALL increment redirectCount by 1 per accepted redirect and saturate at 16'hFFFF.

Reset
REQ-030 SHALL, on a rising edge with reset=1, set newAddress=RESET_PC, state=RUN, counter=0, flush=0, fetchValid=1, misaligned=0, redirectCount=0.
REQ-031 SHALL give reset priority over all other inputs; reset asserted mid-FLUSH SHALL abort the flush at the next edge.
REQ-032 SHALL produce newAddress_next=RESET_PC+GAP in the cycle after reset.

Verification
REQ-033 Reset then 3 idle cycles -> newAddress 0,4,8,12; fetchValid=1, flush=0 throughout.
REQ-034 At PC=0x10, branchTaken=1, newAddress_branch=0x40 -> next cycle PC=0x40, flush=1 for 2 cycles (PC 0x40,0x44), then RUN at 0x48, redirectCount=1.
REQ-035 branchTaken=1 (target 0x80) and jump=1 (target 0x200) in the same cycle -> PC=0x80, redirectCount increments by 1 only.
REQ-036 stall=1 for 3 cycles at PC=0x20 -> PC held at 0x20; stall=1 with jump=1 to 0x100 -> PC=0x100 next cycle.
REQ-037 jump to 0x103 -> PC=0x100, misaligned=1 for one cycle; PC=0xFFFFFFFC idle -> wraps to 0x0.
REQ-038 Redirect during cycle 1 of FLUSH -> counter restarts, flush stays high 2 more cycles; reset asserted during FLUSH -> PC=RESET_PC, flush=0 next cycle.
